// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC sequencer / branch unit.
// Holds the branch condition codes, run/halt states and the target table.
package pc_ctrl_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int IDX_W_DEF = 5;

    typedef enum logic [1:0] {
        ALWAYS = 2'b00,
        EQ     = 2'b01,
        LT     = 2'b10,
        LTE    = 2'b11
    } branch_cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Branch-target table contents: entry i is 8*i.
    // The caller truncates to its PC width, giving 8*i mod 2^PC_W.
    function automatic logic [31:0] lut_entry(input int unsigned i);
        return 32'(8 * i);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: idx selects a constant PC target.
// Ports: idx (IDX_W) in, target (PC_W) out.
module branch_lut
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0] tbl [2**IDX_W];

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_tbl
        assign tbl[i] = PC_W'(lut_entry(i));
    end

    assign target = tbl[idx];

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC sequencer with ALU flag register, conditional branches and run/halt FSM.
// Ports: clk, rst_n, start, stall, halt, flag_wr, alu_equal, alu_lt,
//   branch_en, branch_cond, target_idx in; pc, fetch_en, taken, done,
//   flag_eq, flag_lt, instr_cnt out.
// Define PC_BRANCH_CTRL_INSTR_CNT_EN to build the retired-instruction counter.
module pc_branch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int IDX_W      = IDX_W_DEF,
    parameter int START_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt,
    input  logic             flag_wr,
    input  logic             alu_equal,
    input  logic             alu_lt,
    input  logic             branch_en,
    input  logic [1:0]       branch_cond,
    input  logic [IDX_W-1:0] target_idx,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             taken,
    output logic             done,
    output logic             flag_eq,
    output logic             flag_lt,
    output logic [15:0]      instr_cnt
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_e          state;
    branch_cond_e    cond;
    logic            cond_true;
    logic [PC_W-1:0] target;

    branch_lut #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_lut (
        .idx    (target_idx),
        .target (target)
    );

    assign cond = branch_cond_e'(branch_cond);

    // Uses the registered flags, so a same-cycle flag_wr is not seen yet.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            ALWAYS: cond_true = 1'b1;
            EQ:     cond_true = flag_eq;
            LT:     cond_true = flag_lt;
            LTE:    cond_true = flag_lt | flag_eq;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            fetch_en <= 1'b0;
            taken    <= 1'b0;
            done     <= 1'b0;
            flag_eq  <= 1'b0;
            flag_lt  <= 1'b0;
        end else begin
            taken <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        pc       <= START_PC;
                        fetch_en <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (flag_wr) begin
                            flag_eq <= alu_equal;
                            flag_lt <= alu_lt;
                        end
                        if (halt) begin
                            state    <= DONE;
                            fetch_en <= 1'b0;
                            done     <= 1'b1;
                        end else if (branch_en && cond_true) begin
                            pc    <= target;
                            taken <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    fetch_en <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_BRANCH_CTRL_INSTR_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state != RUN && start) begin
            cnt <= '0;
        end else if (state == RUN && !stall && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign instr_cnt = cnt;
`else
    assign instr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed steps, then random traffic.
// Every cycle is compared against an integer-level reference model.
`timescale 1ns/1ps
module tb_pc_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, halt, flag_wr, alu_equal, alu_lt, branch_en;
    logic [1:0]  branch_cond;
    logic [4:0]  target_idx;
    logic [9:0]  pc;
    logic        fetch_en, taken, done, flag_eq, flag_lt;
    logic [15:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=idle 1=running 2=finished.
    int m_mode, m_pc, m_cnt;
    bit m_eq, m_lt, m_taken;

    always #5 clk = ~clk;

    pc_branch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .halt        (halt),
        .flag_wr     (flag_wr),
        .alu_equal   (alu_equal),
        .alu_lt      (alu_lt),
        .branch_en   (branch_en),
        .branch_cond (branch_cond),
        .target_idx  (target_idx),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .taken       (taken),
        .done        (done),
        .flag_eq     (flag_eq),
        .flag_lt     (flag_lt),
        .instr_cnt   (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef PC_BRANCH_CTRL_INSTR_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
        chk({tag, ".fetch_en"}, 32'(fetch_en), 32'(m_mode == 1));
        chk({tag, ".done"}, 32'(done), 32'(m_mode == 2));
        chk({tag, ".taken"}, 32'(taken), 32'(m_taken));
        chk({tag, ".flag_eq"}, 32'(flag_eq), 32'(m_eq));
        chk({tag, ".flag_lt"}, 32'(flag_lt), 32'(m_lt));
        chk({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(exp_cnt()));
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0;
        m_eq = 0; m_lt = 0; m_taken = 0;
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic step(input string tag, input bit st, input bit sl,
                        input bit h, input bit fw, input bit ae,
                        input bit al, input bit be, input int bc,
                        input int ti);
        bit c;
        start = st; stall = sl; halt = h; flag_wr = fw;
        alu_equal = ae; alu_lt = al; branch_en = be;
        branch_cond = 2'(bc); target_idx = 5'(ti);
        m_taken = 0;
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
            end
        end else if (!sl) begin
            if (m_cnt < 65535) m_cnt++;
            c = (bc == 0) || (bc == 1 && m_eq) || (bc == 2 && m_lt)
                || (bc == 3 && (m_lt || m_eq));
            if (fw) begin
                m_eq = ae; m_lt = al;
            end
            if (h) m_mode = 2;
            else if (be && c) begin
                m_pc = (8 * ti) % 1024; m_taken = 1;
            end else m_pc = (m_pc + 1) % 1024;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic nop(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        start = 0; stall = 0; halt = 0; flag_wr = 0; alu_equal = 0;
        alu_lt = 0; branch_en = 0; branch_cond = 0; target_idx = 0;
        rst_n = 0;
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1;

        nop("idle_hold");
        step("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) nop("seq");
        nop("seq5");

        step("fw_eq", 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("br_eq", 0, 0, 0, 0, 0, 0, 1, 1, 3);
        nop("after_br");
        step("fw_lt_same", 0, 0, 0, 1, 0, 1, 1, 2, 2);
        step("br_lt", 0, 0, 0, 0, 0, 0, 1, 2, 2);
        step("br_lte", 0, 0, 0, 0, 0, 0, 1, 3, 9);

        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 1, 1, 1, 1, 1, 0, 5);

        for (int i = 0; i < 1100 && m_pc != 1023; i++) nop("to_wrap");
        nop("wrap");

        for (int i = 0; i < 20 && m_pc != 7; i++) nop("to7");
        step("halt", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        nop("done_hold");
        step("done_br", 0, 0, 0, 1, 1, 1, 1, 0, 4);
        step("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("run_start_ign", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        step("fw_set", 0, 0, 0, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20 && m_pc != 12; i++) nop("to12");
        rst_n = 0;
        model_reset();
        #2;
        check_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1;
        nop("idle_after_rst");
        step("resume", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom % 8) == 0, ($urandom % 5) == 0,
                 ($urandom % 25) == 0, ($urandom % 3) == 0,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom % 4), int'($urandom % 32));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
